// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared constants and types for the frame SRAM arbiter
package sram_arb_pkg;
  localparam int AW    = 20;
  localparam int DW    = 24;
  localparam int DEPTH = 65536;

  typedef logic port_id_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant; a tie goes to the port not granted last
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  port_id_t r_last;

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (r_last == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (accept) begin
      r_last <= grant[1];
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-client round-robin arbiter for the single-port frame SRAM
// Optional address range check: SRAM_ARB_RANGE_CHECK_EN.
module sram_arbiter #(
  parameter int AW    = sram_arb_pkg::AW,
  parameter int DW    = sram_arb_pkg::DW,
  parameter int DEPTH = sram_arb_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);
  import sram_arb_pkg::*;

  logic [1:0]    w_grant;
  logic          w_accept;
  port_id_t      w_owner;
  cmd_t          w_cmd;
  logic          w_issue;
  logic [DW-1:0] w_rdata;

  logic          r_sram_en;
  logic          r_sram_we;
  logic [AW-1:0] r_sram_addr;
  logic [DW-1:0] r_sram_din;
  logic          r_s1_valid;
  logic          r_s2_valid;
  port_id_t      r_s1_owner;
  port_id_t      r_s2_owner;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({p1_valid, p0_valid}),
    .accept (w_accept),
    .grant  (w_grant)
  );

  assign p0_ready = w_grant[0];
  assign p1_ready = w_grant[1];
  assign w_accept = |w_grant;
  assign w_owner  = w_grant[1];

  always_comb begin
    w_cmd = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
    if (w_grant[1]) begin
      w_cmd = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};
    end
  end

`ifdef SRAM_ARB_RANGE_CHECK_EN
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  logic       w_oor;
  logic       r_s1_oor;
  logic       r_s2_oor;
  logic [1:0] r_err;

  assign w_oor   = (32'(w_cmd.addr) >= DEPTH_U);
  assign w_issue = w_accept && !w_oor;
  assign w_rdata = r_s2_oor ? '0 : sram_dout;
  assign p0_err  = r_err[0];
  assign p1_err  = r_err[1];
`else
  assign w_issue = w_accept;
  assign w_rdata = sram_dout;
  assign p0_err  = 1'b0;
  assign p1_err  = 1'b0;
`endif

  // Read-return stages track owner so data lands on the issuing port two cycles after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sram_en   <= 1'b0;
      r_sram_we   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s1_owner  <= 1'b0;
      r_s2_owner  <= 1'b0;
`ifdef SRAM_ARB_RANGE_CHECK_EN
      r_s1_oor    <= 1'b0;
      r_s2_oor    <= 1'b0;
      r_err       <= 2'b00;
`endif
    end else begin
      r_sram_en <= w_issue;
      if (w_issue) begin
        r_sram_we   <= w_cmd.we;
        r_sram_addr <= w_cmd.addr;
        r_sram_din  <= w_cmd.wdata;
      end
      r_s1_valid <= w_accept && !w_cmd.we;
      r_s1_owner <= w_owner;
      r_s2_valid <= r_s1_valid;
      r_s2_owner <= r_s1_owner;
`ifdef SRAM_ARB_RANGE_CHECK_EN
      r_s1_oor <= w_oor;
      r_s2_oor <= r_s1_oor;
      r_err    <= {w_accept && w_oor && w_owner, w_accept && w_oor && !w_owner};
`endif
    end
  end

  assign sram_en   = r_sram_en;
  assign sram_we   = r_sram_we;
  assign sram_addr = r_sram_addr;
  assign sram_din  = r_sram_din;

  assign p0_rvalid = r_s2_valid && (r_s2_owner == 1'b0);
  assign p1_rvalid = r_s2_valid && (r_s2_owner == 1'b1);
  assign p0_rdata  = w_rdata;
  assign p1_rdata  = w_rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench with reference model and read-response scoreboard
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_valid = 1'b0, p1_valid = 1'b0;
  logic        p0_we = 1'b0, p1_we = 1'b0;
  logic [19:0] p0_addr = '0, p1_addr = '0;
  logic [23:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [23:0] p0_rdata, p1_rdata;
  logic        sram_en, sram_we;
  logic [19:0] sram_addr;
  logic [23:0] sram_din, sram_dout;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  logic [23:0] mem [65536];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr[15:0]] <= sram_din;
      else sram_dout <= mem[sram_addr[15:0]];
    end
  end

  typedef struct {
    logic        port;
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cnt_rv0 = 0;
  int          cnt_rv1 = 0;
  logic        m_last = 1'b1;
  logic        exp_known = 1'b0;
  logic        exp_en, exp_we;
  logic [19:0] exp_addr;
  logic [23:0] exp_din;
  logic [1:0]  exp_err;
  logic [23:0] ref_mem [65536];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : model
    logic [1:0]  g;
    logic        pp, pwe, oor;
    logic [19:0] pa;
    logic [23:0] pd;
    exp_t        e;
    if (exp_known) begin
      chk("sram_en", 32'(sram_en), 32'(exp_en));
      if (exp_en) begin
        chk("sram_we", 32'(sram_we), 32'(exp_we));
        chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
        if (exp_we) chk("sram_din", 32'(sram_din), 32'(exp_din));
      end
      chk("err", 32'({p1_err, p0_err}), 32'(exp_err));
    end
    cnt_rv0 += int'(p0_rvalid);
    cnt_rv1 += int'(p1_rvalid);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rvalid_pair", 32'({p1_rvalid, p0_rvalid}), e.port ? 32'd2 : 32'd1);
      chk("rdata", e.port ? 32'(p1_rdata) : 32'(p0_rdata), 32'(e.data));
    end else if (exp_known) begin
      chk("no_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
    end
    g = 2'b00;
    if (p0_valid && (!p1_valid || m_last)) g = 2'b01;
    else if (p1_valid) g = 2'b10;
    chk("ready", 32'({p1_ready, p0_ready}), 32'(g));
    if (!rst_n) begin
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0; exp_err = 2'b00;
      m_last = 1'b1;
      sb.delete();
      exp_known = 1'b1;
    end else begin
      exp_en = 1'b0;
      exp_err = 2'b00;
      if (g != 2'b00) begin
        pp  = g[1];
        pwe = pp ? p1_we : p0_we;
        pa  = pp ? p1_addr : p0_addr;
        pd  = pp ? p1_wdata : p0_wdata;
`ifdef SRAM_ARB_RANGE_CHECK_EN
        oor = (pa >= 20'h10000);
`else
        oor = 1'b0;
`endif
        if (oor) begin
          exp_err[pp] = 1'b1;
        end else begin
          exp_en = 1'b1; exp_we = pwe; exp_addr = pa; exp_din = pd;
          if (pwe) ref_mem[pa[15:0]] = pd;
        end
        if (!pwe) sb.push_back('{port: pp, data: oor ? 24'h0 : ref_mem[pa[15:0]], due: cyc + 2});
        m_last = pp;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, base1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // p0 write then read back
    p0_valid = 1; p0_we = 1; p0_addr = 20'h00010; p0_wdata = 24'h123456;
    tick();
    p0_valid = 0;
    @(negedge clk);
    chk("t1_en", 32'(sram_en), 32'd1);
    chk("t1_we", 32'(sram_we), 32'd1);
    chk("t1_addr", 32'(sram_addr), 32'h10);
    chk("t1_din", 32'(sram_din), 32'h123456);
    tick();
    p0_valid = 1; p0_we = 0;
    tick();
    p0_valid = 0;
    tick();
    @(negedge clk);
    chk("t1_rvalid0", 32'(p0_rvalid), 32'd1);
    chk("t1_rdata0", 32'(p0_rdata), 32'h123456);
    chk("t1_rvalid1", 32'(p1_rvalid), 32'd0);
    tick();

    // p1 write, then both ports read continuously
    p1_valid = 1; p1_we = 1; p1_addr = 20'h00020; p1_wdata = 24'hABCDEF;
    tick();
    p1_valid = 0;
    tick();
    base0 = cnt_rv0; base1 = cnt_rv1;
    p0_valid = 1; p0_we = 0; p0_addr = 20'h00010;
    p1_valid = 1; p1_we = 0; p1_addr = 20'h00020;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_p0_ready", 32'(p0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_p1_ready", 32'(p1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    p0_valid = 0; p1_valid = 0;
    repeat (3) tick();
    chk("t2_cnt0", 32'(cnt_rv0 - base0), 32'd4);
    chk("t2_cnt1", 32'(cnt_rv1 - base1), 32'd4);

    // write on p0 then immediate read on p1 of the same word
    p0_valid = 1; p0_we = 1; p0_addr = 20'd5; p0_wdata = 24'h5A5A5A;
    tick();
    p0_valid = 0;
    p1_valid = 1; p1_we = 0; p1_addr = 20'd5;
    tick();
    p1_valid = 0;
    tick();
    @(negedge clk);
    chk("t3_rvalid1", 32'(p1_rvalid), 32'd1);
    chk("t3_rdata1", 32'(p1_rdata), 32'h5A5A5A);
    tick();

    // p1 read in flight, reset next cycle alongside a p0 write that must be dropped
    p1_valid = 1; p1_we = 0; p1_addr = 20'h00020;
    tick();
    p1_valid = 0;
    rst_n = 0;
    p0_valid = 1; p0_we = 1; p0_addr = 20'h00010; p0_wdata = 24'hDEAD00;
    tick();
    rst_n = 1;
    p0_valid = 0;
    @(negedge clk);
    chk("t4_en", 32'(sram_en), 32'd0);
    chk("t4_rvalid1", 32'(p1_rvalid), 32'd0);
    tick();
    p0_valid = 1; p0_we = 0; p0_addr = 20'h00010;
    p1_valid = 1; p1_we = 0; p1_addr = 20'h00020;
    @(negedge clk);
    chk("t4_tie_p0", 32'(p0_ready), 32'd1);
    chk("t4_tie_p1", 32'(p1_ready), 32'd0);
    tick();
    tick();
    p0_valid = 0; p1_valid = 0;
    repeat (3) tick();

    // out-of-range read on p0
    p0_valid = 1; p0_we = 1; p0_addr = 20'h00000; p0_wdata = 24'h0F0F0F;
    tick();
    p0_valid = 0;
    tick();
    p0_valid = 1; p0_we = 0; p0_addr = 20'h10000;
    tick();
    p0_valid = 0;
    @(negedge clk);
`ifdef SRAM_ARB_RANGE_CHECK_EN
    chk("t5_en", 32'(sram_en), 32'd0);
    chk("t5_err0", 32'(p0_err), 32'd1);
`else
    chk("t5_en", 32'(sram_en), 32'd1);
    chk("t5_addr", 32'(sram_addr), 32'h10000);
    chk("t5_err0", 32'(p0_err), 32'd0);
`endif
    tick();
    @(negedge clk);
    chk("t5_rvalid0", 32'(p0_rvalid), 32'd1);
`ifdef SRAM_ARB_RANGE_CHECK_EN
    chk("t5_rdata0", 32'(p0_rdata), 32'h0);
`else
    chk("t5_rdata0", 32'(p0_rdata), 32'h0F0F0F);
`endif
    repeat (4) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
